// File: rtl/jpeg_pingpong_block_buffer.sv
// Ping-pong block buffer: fills one bank from a sample stream (optionally
// reordering zigzag input into raster order) while the other bank is
// presented downstream as a single packed block word.
module jpeg_pingpong_block_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 64,
  parameter bit ZIGZAG_EN  = 1'b1,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        wr_zigzag,
  input  logic                        block_abort,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH*DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]            wr_index,
  output logic [1:0]                  full_count
);

  // Zigzag scan position -> raster index, scan position 0 in the top bits.
  localparam logic [6*64-1:0] ZZ_TABLE = {
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DATA_WIDTH-1:0] bank_mem [2][DEPTH];
  logic [1:0]            full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic                  zz_mode;
  logic [IDX_W-1:0]      wr_addr;
  logic                  accept;
  logic                  release_blk;
  logic                  last_sample;

  // Handshake flags depend only on registered state, so no path from
  // wr_valid/out_ready reaches wr_ready/out_valid.
  assign wr_ready    = !full[wr_bank];
  assign out_valid   = full[rd_bank];
  assign accept      = wr_valid && wr_ready && !block_abort;
  assign release_blk = out_valid && out_ready;
  assign last_sample = (wr_index == IDX_W'(DEPTH - 1));
  assign full_count  = {1'b0, full[0]} + {1'b0, full[1]};

  // The first sample of a block decides the mode; later samples use the latch.
  if (ZIGZAG_EN) begin : g_zz
    logic zz_active;
    assign zz_active = (wr_index == '0) ? wr_zigzag : zz_mode;
    assign wr_addr   = zz_active ? IDX_W'(ZZ_TABLE[6*(63-int'(wr_index)) +: 6]) : wr_index;
  end else begin : g_raster
    assign wr_addr = wr_index;
  end

  // Write pointer, zigzag latch, bank flags and read pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_index <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= 2'b00;
      zz_mode  <= 1'b0;
    end else begin
      if (block_abort) begin
        wr_index <= '0;
      end else if (accept) begin
        if (wr_index == '0)
          zz_mode <= wr_zigzag && ZIGZAG_EN;
        if (last_sample) begin
          wr_index      <= '0;
          wr_bank       <= !wr_bank;
          full[wr_bank] <= 1'b1;
        end else begin
          wr_index <= wr_index + IDX_W'(1);
        end
      end
      // A completing write and a read release always target different banks.
      if (release_blk) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end

  // Bank storage; contents are cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < DEPTH; i++)
          bank_mem[b][i] <= '0;
    end else if (accept) begin
      bank_mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Pack the presented bank, element 0 in the most significant slot.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < DEPTH; i++)
      out_data[(DEPTH-i)*DATA_WIDTH-1 -: DATA_WIDTH] = bank_mem[rd_bank][i];
  end

endmodule

// File: tb/tb_jpeg_pingpong_block_buffer.sv
// Directed self-checking bench for jpeg_pingpong_block_buffer.
module tb_jpeg_pingpong_block_buffer;

  logic         clock;
  logic         reset_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [11:0]  wr_data;
  logic         wr_zigzag;
  logic         block_abort;
  logic         out_valid;
  logic         out_ready;
  logic [767:0] out_data;
  logic [5:0]   wr_index;
  logic [1:0]   full_count;

  int checks;
  int fails;
  int stall_cycles;

  jpeg_pingpong_block_buffer #(
    .DATA_WIDTH(12),
    .DEPTH(64),
    .ZIGZAG_EN(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .wr_zigzag(wr_zigzag),
    .block_abort(block_abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .wr_index(wr_index),
    .full_count(full_count)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] elem(input int i);
    return out_data[767-12*i -: 12];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Offer one sample at a negedge and return at the negedge after it is taken.
  task automatic applyStimulus(input logic [11:0] d, input logic zz);
    int waited;
    waited    = 0;
    wr_valid  = 1'b1;
    wr_data   = d;
    wr_zigzag = zz;
    while (!wr_ready && waited < 300) begin
      @(posedge clock);
      @(negedge clock);
      waited++;
    end
    stall_cycles += waited;
    if (waited >= 300) begin
      checkOutput("push_timeout", 64'(waited), 64'(0));
    end else begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic pushBlock(input int base, input logic zz_first, input logic zz_rest);
    for (int k = 0; k < 64; k++)
      applyStimulus(12'(base + k), (k == 0) ? zz_first : zz_rest);
  endtask

  task automatic idleInput();
    wr_valid    = 1'b0;
    wr_zigzag   = 1'b0;
    block_abort = 1'b0;
  endtask

  task automatic doReset();
    idleInput();
    out_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    checks       = 0;
    fails        = 0;
    stall_cycles = 0;
    reset_n      = 1'b0;
    wr_data      = '0;
    out_ready    = 1'b0;
    idleInput();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_wr_ready", 64'(wr_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_full_count", 64'(full_count), 64'(0));
    checkOutput("rst_wr_index", 64'(wr_index), 64'(0));
    checkOutput("rst_out_data_zero", 64'(|out_data), 64'(0));

    $display("[TB] raster fill");
    out_ready = 1'b1;
    pushBlock(0, 1'b0, 1'b0);
    idleInput();
    checkOutput("ras_out_valid", 64'(out_valid), 64'(1));
    checkOutput("ras_elem0", 64'(elem(0)), 64'(0));
    checkOutput("ras_elem1", 64'(elem(1)), 64'(1));
    checkOutput("ras_elem63", 64'(elem(63)), 64'(63));
    checkOutput("ras_full_count", 64'(full_count), 64'(1));
    checkOutput("ras_wr_index", 64'(wr_index), 64'(0));
    @(posedge clock);
    @(negedge clock);
    checkOutput("ras_drained_valid", 64'(out_valid), 64'(0));
    checkOutput("ras_drained_count", 64'(full_count), 64'(0));

    $display("[TB] zigzag fill");
    pushBlock(0, 1'b1, 1'b0);
    idleInput();
    checkOutput("zz_out_valid", 64'(out_valid), 64'(1));
    checkOutput("zz_elem8", 64'(elem(8)), 64'(2));
    checkOutput("zz_elem2", 64'(elem(2)), 64'(5));
    checkOutput("zz_elem9", 64'(elem(9)), 64'(4));
    checkOutput("zz_elem1", 64'(elem(1)), 64'(1));
    checkOutput("zz_elem63", 64'(elem(63)), 64'(63));
    @(posedge clock);
    @(negedge clock);
    checkOutput("zz_drained_count", 64'(full_count), 64'(0));

    $display("[TB] back-pressure");
    doReset();
    out_ready = 1'b0;
    pushBlock(100, 1'b0, 1'b0);
    pushBlock(200, 1'b0, 1'b0);
    wr_data = 12'd300;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
    end
    checkOutput("bp_wr_ready_low", 64'(wr_ready), 64'(0));
    checkOutput("bp_full_count", 64'(full_count), 64'(2));
    checkOutput("bp_wr_index_held", 64'(wr_index), 64'(0));
    checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
    checkOutput("bp_stable_elem0", 64'(elem(0)), 64'(100));
    checkOutput("bp_stable_elem63", 64'(elem(63)), 64'(163));
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput("bp_wr_ready_back", 64'(wr_ready), 64'(1));
    checkOutput("bp_count_after_rel", 64'(full_count), 64'(1));
    checkOutput("bp_blk1_elem0", 64'(elem(0)), 64'(200));
    checkOutput("bp_blk1_elem63", 64'(elem(63)), 64'(263));
    @(posedge clock);
    @(negedge clock);
    wr_data = 12'd301;
    @(posedge clock);
    @(negedge clock);
    idleInput();
    checkOutput("bp_remaining_two", 64'(wr_index), 64'(2));
    checkOutput("bp_blk1_still_elem0", 64'(elem(0)), 64'(200));

    $display("[TB] continuous stream");
    doReset();
    out_ready    = 1'b1;
    stall_cycles = 0;
    for (int b = 0; b < 4; b++) begin
      pushBlock(b * 256, 1'b0, 1'b0);
      checkOutput($sformatf("cont_valid_b%0d", b), 64'(out_valid), 64'(1));
      checkOutput($sformatf("cont_elem0_b%0d", b), 64'(elem(0)), 64'(b * 256));
      checkOutput($sformatf("cont_elem63_b%0d", b), 64'(elem(63)), 64'(b * 256 + 63));
      checkOutput($sformatf("cont_rd_bank_b%0d", b), 64'(dut.rd_bank), 64'(b % 2));
      checkOutput($sformatf("cont_count_b%0d", b), 64'(full_count), 64'(1));
    end
    idleInput();
    checkOutput("cont_no_stall", 64'(stall_cycles), 64'(0));
    @(posedge clock);
    @(negedge clock);
    checkOutput("cont_drained", 64'(out_valid), 64'(0));

    $display("[TB] abort");
    doReset();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++)
      applyStimulus(12'(500 + k), 1'b0);
    checkOutput("abort_pre_index", 64'(wr_index), 64'(20));
    wr_data     = 12'd999;
    block_abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    idleInput();
    checkOutput("abort_index", 64'(wr_index), 64'(0));
    checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
    checkOutput("abort_full_count", 64'(full_count), 64'(0));
    pushBlock(700, 1'b0, 1'b1);
    idleInput();
    checkOutput("abort_clean_valid", 64'(out_valid), 64'(1));
    checkOutput("abort_clean_elem0", 64'(elem(0)), 64'(700));
    checkOutput("abort_clean_elem2", 64'(elem(2)), 64'(702));
    checkOutput("abort_clean_elem8", 64'(elem(8)), 64'(708));
    checkOutput("abort_clean_elem20", 64'(elem(20)), 64'(720));
    checkOutput("abort_clean_elem63", 64'(elem(63)), 64'(763));
    @(posedge clock);
    @(negedge clock);

    $display("[TB] reset mid-operation");
    doReset();
    out_ready = 1'b0;
    pushBlock(40, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++)
      applyStimulus(12'(900 + k), 1'b0);
    idleInput();
    checkOutput("mid_pre_index", 64'(wr_index), 64'(30));
    checkOutput("mid_pre_count", 64'(full_count), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_out_valid", 64'(out_valid), 64'(0));
    checkOutput("mid_wr_ready", 64'(wr_ready), 64'(1));
    checkOutput("mid_wr_index", 64'(wr_index), 64'(0));
    checkOutput("mid_full_count", 64'(full_count), 64'(0));
    checkOutput("mid_out_data_zero", 64'(|out_data), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/jpeg_pingpong_block_buffer.md
# jpeg_pingpong_block_buffer

Double-buffered (ping-pong) pixel/coefficient block buffer for the JPEG encoder datapath, parametrised in sample width and block depth. It accepts one sample per clock on a valid/ready stream and assembles complete blocks. An optional zigzag-to-raster reorder runs on the write side. Each finished block is presented as one packed word on a valid/ready output, so the upstream stage can fill the next block while downstream (DCT / quantiser) consumes the previous one.

## Interface
- DATA_WIDTH, 12, bits per sample.
- DEPTH, 64, samples per block; power of two, >= 4.
- ZIGZAG_EN, 1, instantiates the 64-entry zigzag table; legal only with DEPTH == 64, otherwise must be 0.
- IDX_W, $clog2(DEPTH), derived; not to be overridden.

- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  sample present on wr_data.
- wr_ready  out  1  buffer can accept a sample this cycle.
- wr_data  in  DATA_WIDTH  input sample.
- wr_zigzag  in  1  block arrives in zigzag order; sampled with the first sample of each block.
- block_abort  in  1  discard the partially filled block.
- out_valid  out  1  a complete block is on out_data.
- out_ready  in  1  downstream accepts the block.
- out_data  out  DEPTH*DATA_WIDTH  packed block; element 0 at the MSBs [DEPTH*DATA_WIDTH-1 -: DATA_WIDTH], element DEPTH-1 at the LSBs.
- wr_index  out  IDX_W  number of samples already accepted into the current block.
- full_count  out  2  number of banks holding a complete block (0..2).

## Operation
- Storage: two banks, each DEPTH x DATA_WIDTH. Each bank has a full flag.
- Pointers: wr_bank is the bank being filled; rd_bank is the bank being presented.
- wr_ready = !full[wr_bank]. out_valid = full[rd_bank]. out_data = packed contents of rd_bank.
- A write is accepted when wr_valid && wr_ready.
  - Raster mode: the sample goes to wr_bank[wr_index].
  - Zigzag mode: the sample goes to wr_bank[ZZ[wr_index]], where ZZ is the standard JPEG zigzag-scan-position-to-raster-index table (ZZ[0]=0, ZZ[1]=1, ZZ[2]=8, ZZ[3]=16, ZZ[4]=9, ZZ[5]=2, ... ZZ[63]=63). Output is therefore always raster order.
- zigzag mode bit: latched when a sample is accepted with wr_index == 0. Samples at later indices use the latched bit, and wr_zigzag is ignored for them. With ZIGZAG_EN = 0 the mode is always raster.
- Index advance: wr_index increments by 1 per accepted sample.
- Block completion: on the accepted sample with wr_index == DEPTH-1:
  - full[wr_bank] is set;
  - wr_bank toggles;
  - wr_index wraps to 0.
- Read handshake: when out_valid && out_ready, full[rd_bank] is cleared and rd_bank toggles. The bank contents are not cleared.
- Simultaneous completion and read release: both updates take effect in the same cycle. They always act on different banks. full_count is unchanged.
- block_abort: sets wr_index to 0 and leaves the zigzag latch free for the next block.
  - It has priority over a same-cycle write; that sample is dropped, even if wr_ready was high.
  - It has no effect on full banks, rd_bank or out_valid.
- Stalled output: out_valid and out_data hold stable until accepted. This follows from bank contents being unchanged while the bank is full.

## Timing
- Reset values:
  - wr_bank = 0, rd_bank = 0, both full flags 0, wr_index = 0, zigzag latch 0;
  - outputs: wr_ready = 1, out_valid = 0, full_count = 0, out_data = all zeros (bank memories reset to 0).
- Reset may assert mid-block or with a block pending. All state returns to the reset values immediately (asynchronously), and partial or full blocks are lost.
- Latency: the last sample of a block is accepted at edge N; out_valid = 1 and out_data is valid from after edge N.
- Throughput: one sample per clock, with no bubble at the block boundary while the other bank is free.
- Sustained rate: the input can run at 1 sample/clock indefinitely if out_ready accepts each block within DEPTH cycles of it becoming valid.
- Back-pressure: with both banks full, wr_ready = 0. wr_ready returns to 1 in the cycle after an out_valid && out_ready acceptance.
- wr_ready and out_valid are combinational functions of registered flags only. There is no combinational path from wr_valid or out_ready to either of them.

## Test plan
- Raster fill: after reset, stream samples 0..63 with wr_zigzag=0 and out_ready=1 -> out_valid one cycle after the 64th accept; out_data[767:756]=0, out_data[11:0]=63; full_count returns to 0 after acceptance.
- Zigzag fill: stream values v[k]=k with wr_zigzag=1 on the first sample only -> element 8 (raster) = 2, element 2 = 5, element 63 = 63.
- Back-pressure: out_ready=0, stream 130 valid samples back-to-back -> after 128 accepts wr_ready=0 and full_count=2; out_data stays stable holding block 0. Raising out_ready for one cycle -> out_data shows block 1, and the remaining 2 samples are accepted.
- Continuous stream: out_ready=1, 4 blocks of 1 sample/clock -> wr_ready never drops; blocks come out alternately from bank 0 and bank 1, with out_valid one cycle after each block's last sample.
- Abort: accept 20 samples, assert block_abort together with wr_valid -> wr_index=0 and the sample is dropped; a following clean 64-sample block emerges intact.
- Reset mid-operation: bank 0 full, 30 samples into bank 1, drive reset_n low -> out_valid=0, wr_ready=1, wr_index=0, full_count=0 without waiting for a clock edge.
